// File: rtl/wb_stage_pkg.sv
// Shared writeback encodings for the core: source selects, load modes and the
// retire-counter default (enabled by defining WB_RETIRE_CNT_EN).
package wb_stage_pkg;

    localparam int WB_ALU  = 0;
    localparam int WB_EXT  = 1;
    localparam int WB_PC   = 2;
    localparam int WB_DRAM = 3;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4,
        LD_WU = 3'd5,
        LD_D  = 3'd6
    } ld_mode_e;

`ifdef WB_RETIRE_CNT_EN
    localparam bit RETIRE_CNT_EN = 1'b1;
`else
    localparam bit RETIRE_CNT_EN = 1'b0;
`endif

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB pipeline bundle plus the register-file write port and retire count.
// master drives the MEM-stage side, slave is the writeback stage.
interface wb_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int RADDR_W = 5
);
    logic                    stall;
    logic                    flush;
    logic                    mem_valid;
    logic                    mem_rf_we;
    logic [RADDR_W-1:0]      mem_wR;
    logic [SEL_W-1:0]        mem_rf_wsel;
    logic [2:0]              mem_ld_mode;
    logic [NUM_SRC*XLEN-1:0] mem_src;
    logic                    rf_we;
    logic [RADDR_W-1:0]      wR;
    logic [XLEN-1:0]         wD;
    logic                    wb_valid;
    logic [63:0]             retire_cnt;

    modport master (
        output stall, flush, mem_valid, mem_rf_we, mem_wR, mem_rf_wsel, mem_ld_mode, mem_src,
        input  rf_we, wR, wD, wb_valid, retire_cnt
    );

    modport slave (
        input  stall, flush, mem_valid, mem_rf_we, mem_wR, mem_rf_wsel, mem_ld_mode, mem_src,
        output rf_we, wR, wD, wb_valid, retire_cnt
    );
endinterface

// File: rtl/wb_load_align.sv
// Load aligner/extender: picks the byte/half/word at the address offset and
// sign- or zero-extends it to XLEN. Purely combinational.
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  raw,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       ld_mode,
    output logic [XLEN-1:0]  data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    logic        word_hi;

    // Only a 64-bit datapath has two words to choose from.
    assign word_hi = (XLEN == 64) ? offset[OFF_W-1] : 1'b0;

    always_comb begin
        byte_v = 8'(raw >> {offset, 3'b000});
        half_v = 16'(raw >> {offset[OFF_W-1:1], 4'b0000});
        word_v = 32'(raw >> {word_hi, 5'b00000});
        data   = raw;
        case (ld_mode)
            LD_B:    data = XLEN'($signed(byte_v));
            LD_BU:   data = XLEN'(byte_v);
            LD_H:    data = XLEN'($signed(half_v));
            LD_HU:   data = XLEN'(half_v);
            LD_W:    data = XLEN'($signed(word_v));
            LD_WU:   data = XLEN'(word_v);
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, N-source select and load alignment feeding
// the register-file write port. Retire counter built only with WB_RETIRE_CNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int RADDR_W = 5
) (
    input  logic     cpu_clk,
    input  logic     cpu_rst,
    wb_stage_if.slave bus
);
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic                    reg_valid;
    logic                    reg_rf_we;
    logic [RADDR_W-1:0]      reg_wR;
    logic [SEL_W-1:0]        reg_sel;
    logic [2:0]              reg_ld;
    logic [NUM_SRC*XLEN-1:0] reg_src;

    logic [XLEN-1:0]         sel_data;
    logic [XLEN-1:0]         ld_data;
    logic                    sel_ok;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            reg_valid <= 1'b0;
            reg_rf_we <= 1'b0;
            reg_wR    <= '0;
            reg_sel   <= '0;
            reg_ld    <= '0;
            reg_src   <= '0;
        end else if (bus.flush) begin
            reg_valid <= 1'b0;
            reg_rf_we <= 1'b0;
            reg_wR    <= '0;
            reg_sel   <= '0;
            reg_ld    <= '0;
            reg_src   <= '0;
        end else if (!bus.stall) begin
            reg_valid <= bus.mem_valid;
            reg_rf_we <= bus.mem_rf_we;
            reg_wR    <= bus.mem_wR;
            reg_sel   <= bus.mem_rf_wsel;
            reg_ld    <= bus.mem_ld_mode;
            reg_src   <= bus.mem_src;
        end
    end

    // Selects past the last populated slot yield zero and suppress the write.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (reg_sel == SEL_W'(k)) sel_data = reg_src[k*XLEN +: XLEN];
        end
        sel_ok = (int'(reg_sel) < NUM_SRC);
    end

    wb_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .raw     (sel_data),
        .offset  (reg_src[WB_ALU*XLEN +: OFF_W]),
        .ld_mode (reg_ld),
        .data    (ld_data)
    );

    assign bus.wD       = !sel_ok ? '0 : (reg_sel == SEL_W'(WB_DRAM)) ? ld_data : sel_data;
    assign bus.rf_we    = reg_valid & reg_rf_we & (reg_wR != '0) & sel_ok;
    assign bus.wR       = reg_wR;
    assign bus.wb_valid = reg_valid;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)                       retire_q <= '0;
        else if (reg_valid && !bus.stall)  retire_q <= retire_q + 64'd1;
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = '0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage for the pipelined RISC-V core.
- Combines the MEM/WB pipeline register, an N-source writeback select and a load-data aligner/extender.
- Drives the register file write port (rf_we, wR, wD) and publishes the same value to the hazard/forwarding unit.
- Successor to the fixed 3-source combinational writeback select:
  - adds the DRAM source and sub-word loads;
  - adds pipeline hold/flush;
  - makes width and source count parametric.

Parameters:
- XLEN, 32, datapath width. Must be 32 or 64.
- NUM_SRC, 4, number of writeback sources. Minimum 3.
- SEL_W, 2, width of rf_wsel. Must satisfy 2^SEL_W >= NUM_SRC.
- RADDR_W, 5, register index width.

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  asynchronous active-high reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  load a bubble into MEM/WB
- mem_valid  in  1  MEM-stage slot holds a real instruction
- mem_rf_we  in  1  instruction writes rd
- mem_wR  in  RADDR_W  destination register
- mem_rf_wsel  in  SEL_W  source select; encodings from package
- mem_ld_mode  in  3  load width/sign; encodings from package
- mem_src  in  NUM_SRC*XLEN  packed sources; slot k = bits [k*XLEN +: XLEN]
- rf_we  out  1  register file write enable
- wR  out  RADDR_W  register file write index
- wD  out  XLEN  register file write data
- wb_valid  out  1  WB slot holds a real instruction
- retire_cnt  out  64  retired-instruction count (optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - all MEM/WB fields clear to 0;
  - rf_we=0, wR=0, wD=0, wb_valid=0, retire_cnt=0.
- Capture on posedge cpu_clk. Priority: flush > stall > load.
  - flush: valid=0, rf_we field=0; other fields don't-care, cleared to 0.
  - stall: all fields hold.
  - otherwise: all mem_* inputs are registered.
- Latency: wD and rf_we are combinational from the registered fields, valid in the cycle after capture. No path from mem_* inputs to outputs.
- Write enable and index:
  - rf_we = reg_valid & reg_rf_we & (reg_wR != 0).
  - wR = reg_wR.
- Source select:
  - WB_ALU=0, WB_EXT=1, WB_PC=2, WB_DRAM=3; slot index equals the encoding.
  - If the select is >= NUM_SRC: wD=0 and rf_we is forced 0.
- Load path: applies only when sel==WB_DRAM. The byte offset is the low bits of slot WB_ALU (the effective address). XLEN=64 uses 3 offset bits.
  - LD_B / LD_BU: byte at offset, sign-/zero-extended to XLEN.
  - LD_H / LD_HU: halfword at offset[..1] (offset bit 0 ignored), sign-/zero-extended.
  - LD_W / LD_WU: word; sign-/zero-extended when XLEN=64. At XLEN=32 both pass the word through unchanged.
  - LD_D: XLEN=64 only. At XLEN=32 it behaves as LD_W.
  - Unknown ld_mode: full-width pass-through.
- Bubble: when wb_valid=0, wD is still driven from the registered fields but is meaningless; rf_we=0.
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: clears immediately; the held instruction is lost.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retire_cnt increments by 1 on each posedge where wb_valid=1 and stall=0;
  - wraps modulo 2^64;
  - cleared by reset.
- Undefined: retire_cnt is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package (defines header used by the core):
  - WB_ALU/WB_EXT/WB_PC/WB_DRAM;
  - LD_B=0, LD_BU=1, LD_H=2, LD_HU=3, LD_W=4, LD_WU=5, LD_D=6;
  - the WB_RETIRE_CNT_EN default.
- One sub-module: wb_load_align. Purely combinational; inputs raw word, offset and ld_mode; output extended XLEN data.
- Pipeline register and select logic stay in wb_stage.

Test Plan:
- Reset: assert cpu_rst mid-cycle with valid data loaded -> outputs 0 immediately, before the next edge; rf_we=0.
- Select: capture sel=WB_PC, src2=0x0000_1004, wR=5, rf_we=1, valid=1 -> next cycle wD=0x0000_1004, wR=5, rf_we=1.
- Load: sel=WB_DRAM, DRAM slot=0x80FF_7F01, addr low=2'b11, LD_B -> wD=0xFFFF_FF80.
  - Same stimulus with LD_BU -> wD=0x0000_0080.
  - Same with LD_H and offset 2 -> wD=0xFFFF_80FF.
- Pipeline control:
  - stall=1 and flush=1 together -> next cycle wb_valid=0, rf_we=0.
  - stall alone for 3 cycles -> outputs constant across all 3.
- x0 write: wR=0 with rf_we=1 -> rf_we out=0.
  - sel=3 with NUM_SRC=3 -> wD=0, rf_we=0.
- Retire counter: with WB_RETIRE_CNT_EN defined, 10 valid instructions, of which 2 arrive as flushed bubbles, plus 3 stall cycles -> retire_cnt=8.
